vm2002_change_dispenser: RTL and testbench
==========================================

Name: vm2002_change_dispenser

Overview:
- Downstream stage of the vm2002 vending controller. It takes the change owed after a sale (in cents, same units as vm2002 `balance`) and pays it out one coin at a time to the coin-ejector mechanism.
- Coins are taken from three internal tube inventories: quarter, dime and nickel. Payout is greedy, largest coin first, with fallback to smaller coins when a tube is empty.
- Tubes are refilled over a simple supplier interface.
- The block reports completion, shortfall error and any undispensed residue.

Parameters:
- CNT_W, 8, width of each tube counter.
- MAX_COINS, 200, tube capacity; refills saturate here.
- TIMEOUT, 255, maximum EJECT wait cycles for eject_ready before abort.

Ports:
- clk  in  1  system clock, all logic on posedge.
- hrst_n  in  1  reset; one clock; synchronous, active-low.
- start  in  1  pulse requesting a payout; accepted only in IDLE.
- amount  in  16  change owed in cents (e.g. 16'h41 = 65c); sampled with start.
- eject_ready  in  1  ejector ready; a handshake completes when coin_valid && eject_ready.
- refill  in  1  supplier refill strobe.
- refill_coin  in  2  01 nickel, 10 dime, 11 quarter, 00 ignored.
- refill_qty  in  4  coins added by the refill.
- coin_out  out  2  coin to eject; same encoding as refill_coin.
- coin_valid  out  1  coin_out is valid.
- busy  out  1  payout in progress.
- done  out  1  one-cycle pulse when payout completes fully.
- error  out  1  payout aborted; sticky until the next accepted start or reset.
- remaining  out  16  live undispensed amount.
- q_count, d_count, n_count  out  CNT_W each  tube inventories.

Behaviour:
- **Reset** (hrst_n=0 at a posedge):
  - State goes to IDLE.
  - coin_out, coin_valid, busy, done, error and remaining all go to 0.
  - All tube counts go to 0.
  - Reset mid-payout aborts at that edge; nothing further is dispensed.
- **States:** IDLE, SELECT, EJECT, DONE, ERROR. All outputs are registered.
- **IDLE:**
  - start=1: latch amount into rem, clear error, set busy=1, go to SELECT.
  - refill=1 with refill_coin!=00: target count = min(count+refill_qty, MAX_COINS).
  - refill and start in the same cycle: both take effect; the refill lands before the first SELECT.
- **SELECT** (1 cycle), first matching rule wins:
  - rem==0 -> DONE.
  - rem>=25 and q_count>0 -> coin_out=11.
  - else rem>=10 and d_count>0 -> coin_out=10.
  - else rem>=5 and n_count>0 -> coin_out=01.
  - else -> ERROR.
  - On any coin choice: coin_valid=1 and go to EJECT.
- **EJECT:**
  - coin_out and coin_valid are held stable until the handshake.
  - In the handshake cycle: rem -= coin value (25/10/5), the matching tube count decrements by 1, coin_valid drops at the next edge, and the state returns to SELECT.
  - A wait counter clears on EJECT entry and increments each non-handshake cycle.
  - When the counter reaches TIMEOUT: go to ERROR, coin_valid drops, and no deduction is made.
- **DONE:** done=1 for exactly one cycle, busy=0 at the same edge, then IDLE.
- **ERROR:** error=1 (sticky), busy=0, remaining holds the undispensed rem, then IDLE next cycle.
- **Ignored inputs:**
  - start while busy is ignored.
  - refill outside IDLE is ignored.
- **Timing:**
  - Start sampled at edge k: first coin_valid appears after edge k+1.
  - With eject_ready held high, one coin per 2 cycles.
  - amount=0: done after edge k+1, with no coin_valid ever asserted.
- **Arithmetic:**
  - rem is 16 bits and never underflows, because selection guarantees rem >= coin value.
  - Amounts that are not a multiple of 5 end in ERROR with remaining = residue (1..4).
  - Tube counts never go below 0 or above MAX_COINS.
- **Outputs:**
  - remaining always mirrors rem.
  - busy=1 from the edge after start acceptance until the DONE/ERROR exit edge.

Test Plan:
1. Reset; refill Q/D/N qty 4 each; start amount=65, eject_ready=1 -> coin_out sequence 11,11,10,01, one done pulse, remaining=0, counts Q=2 D=3 N=3, error=0.
2. q_count=0, d_count=10; start amount=30 -> coin_out 10,10,10, done, d_count=7.
3. start amount=0 -> done pulse after edge k+1, coin_valid never asserted, counts unchanged.
4. n_count=5; start amount=7 -> one nickel, then error=1, remaining=2, n_count=4, done never pulses. The next start clears error.
5. Tubes loaded, start amount=25, eject_ready=0 for TIMEOUT cycles -> coin_out=11 stable throughout, then error=1, remaining=25, q_count unchanged. Assert hrst_n low during a later payout -> all outputs 0 at the next edge.
6. n_count=195, refill nickel qty 15 -> n_count=200 (saturates). During a busy payout, apply start and refill -> both ignored; counts and rem are unaffected.

Source files
------------

// File: rtl/vm2002_change_dispenser_if.sv
// Payout, ejector and supplier-refill signals of the vm2002 change dispenser.
// The dispenser drives the slave side; the controller/ejector/supplier side uses master.
interface vm2002_change_dispenser_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [15:0]      amount;
    logic             eject_ready;
    logic             refill;
    logic [1:0]       refill_coin;
    logic [3:0]       refill_qty;
    logic [1:0]       coin_out;
    logic             coin_valid;
    logic             busy;
    logic             done;
    logic             error;
    logic [15:0]      remaining;
    logic [CNT_W-1:0] q_count;
    logic [CNT_W-1:0] d_count;
    logic [CNT_W-1:0] n_count;

    modport master (
        output start, amount, eject_ready, refill, refill_coin, refill_qty,
        input  coin_out, coin_valid, busy, done, error, remaining,
               q_count, d_count, n_count
    );

    modport slave (
        input  start, amount, eject_ready, refill, refill_coin, refill_qty,
        output coin_out, coin_valid, busy, done, error, remaining,
               q_count, d_count, n_count
    );
endinterface

// File: rtl/vm2002_change_dispenser.sv
// Greedy quarter/dime/nickel payout from tube inventories; first coin one cycle after start, one coin per 2 cycles.
// coin_valid/coin_out hold until eject_ready; aborts to error after TIMEOUT stalled cycles.
module vm2002_change_dispenser #(
    parameter int CNT_W     = 8,
    parameter int MAX_COINS = 200,
    parameter int TIMEOUT   = 255
) (
    input  logic                         clk,
    input  logic                         hrst_n,
    vm2002_change_dispenser_if.slave     io_dsp
);
    localparam int                W_W       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W:0]    L_MAX     = (CNT_W + 1)'(MAX_COINS);
    localparam logic [W_W-1:0]    L_TO_LAST = W_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  L_ONE     = CNT_W'(1);
    localparam logic [1:0]        C_N       = 2'b01;
    localparam logic [1:0]        C_D       = 2'b10;
    localparam logic [1:0]        C_Q       = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_SELECT, S_EJECT, S_DONE, S_ERROR} state_t;

    state_t           r_state, w_state_nxt;
    logic [15:0]      r_rem, w_rem_nxt;
    logic [1:0]       r_coin, w_coin_nxt;
    logic             r_vld, w_vld_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             r_err, w_err_nxt;
    logic [CNT_W-1:0] r_q, w_q_nxt;
    logic [CNT_W-1:0] r_d, w_d_nxt;
    logic [CNT_W-1:0] r_n, w_n_nxt;
    logic [W_W-1:0]   r_wait, w_wait_nxt;

    function automatic logic [CNT_W-1:0] f_fill(input logic [CNT_W-1:0] cnt, input logic [3:0] qty);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(CNT_W-3){1'b0}}, qty};
        return (sum > L_MAX) ? L_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_coin_nxt  = r_coin;
        w_vld_nxt   = r_vld;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err;
        w_q_nxt     = r_q;
        w_d_nxt     = r_d;
        w_n_nxt     = r_n;
        w_wait_nxt  = r_wait;
        unique case (r_state)
            S_IDLE: begin
                // Refill lands at the same edge as start, so SELECT already sees it.
                if (io_dsp.refill) begin
                    case (io_dsp.refill_coin)
                        C_Q:     w_q_nxt = f_fill(r_q, io_dsp.refill_qty);
                        C_D:     w_d_nxt = f_fill(r_d, io_dsp.refill_qty);
                        C_N:     w_n_nxt = f_fill(r_n, io_dsp.refill_qty);
                        default: ;
                    endcase
                end
                if (io_dsp.start) begin
                    w_rem_nxt   = io_dsp.amount;
                    w_err_nxt   = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_SELECT;
                end
            end
            S_SELECT: begin
                w_wait_nxt = '0;
                if (r_rem == 16'd0) begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_DONE;
                end else if (r_rem >= 16'd25 && r_q != '0) begin
                    w_coin_nxt  = C_Q;
                    w_vld_nxt   = 1'b1;
                    w_state_nxt = S_EJECT;
                end else if (r_rem >= 16'd10 && r_d != '0) begin
                    w_coin_nxt  = C_D;
                    w_vld_nxt   = 1'b1;
                    w_state_nxt = S_EJECT;
                end else if (r_rem >= 16'd5 && r_n != '0) begin
                    w_coin_nxt  = C_N;
                    w_vld_nxt   = 1'b1;
                    w_state_nxt = S_EJECT;
                end else begin
                    w_err_nxt   = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_ERROR;
                end
            end
            S_EJECT: begin
                if (io_dsp.eject_ready) begin
                    w_vld_nxt   = 1'b0;
                    w_state_nxt = S_SELECT;
                    case (r_coin)
                        C_Q: begin
                            w_rem_nxt = r_rem - 16'd25;
                            w_q_nxt   = r_q - L_ONE;
                        end
                        C_D: begin
                            w_rem_nxt = r_rem - 16'd10;
                            w_d_nxt   = r_d - L_ONE;
                        end
                        default: begin
                            w_rem_nxt = r_rem - 16'd5;
                            w_n_nxt   = r_n - L_ONE;
                        end
                    endcase
                end else if (r_wait == L_TO_LAST) begin
                    // Ejector stalled: abandon this coin with rem and tubes untouched.
                    w_vld_nxt   = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_ERROR;
                end else begin
                    w_wait_nxt = r_wait + W_W'(1);
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_ERROR: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!hrst_n) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_coin  <= '0;
            r_vld   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_q     <= '0;
            r_d     <= '0;
            r_n     <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_coin  <= w_coin_nxt;
            r_vld   <= w_vld_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_q     <= w_q_nxt;
            r_d     <= w_d_nxt;
            r_n     <= w_n_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    assign io_dsp.coin_out   = r_coin;
    assign io_dsp.coin_valid = r_vld;
    assign io_dsp.busy       = r_busy;
    assign io_dsp.done       = r_done;
    assign io_dsp.error      = r_err;
    assign io_dsp.remaining  = r_rem;
    assign io_dsp.q_count    = r_q;
    assign io_dsp.d_count    = r_d;
    assign io_dsp.n_count    = r_n;
endmodule

// File: tb/tb_vm2002_change_dispenser.sv
// Directed bench for vm2002_change_dispenser: a payout-level model predicts every output each cycle,
// and literal expectations pin the model on the scenarios of interest.
module tb_vm2002_change_dispenser;
    localparam int TIMEOUT   = 255;
    localparam int MAX_COINS = 200;

    logic clk = 1'b0;
    logic hrst_n;
    always #5 clk = ~clk;

    vm2002_change_dispenser_if #(.CNT_W(8)) dsp_if ();

    vm2002_change_dispenser #(
        .CNT_W(8), .MAX_COINS(MAX_COINS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .hrst_n(hrst_n),
        .io_dsp(dsp_if.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: inventory indexed by coin code, payout written as a sequential story.
    int inv[4];
    int e_rem  = 0;
    int e_coin = 0;
    bit e_vld  = 1'b0;
    bit e_busy = 1'b0;
    bit e_done = 1'b0;
    bit e_err  = 1'b0;
    bit m_live = 1'b0;

    function automatic int pick(input int rem);
        if (rem >= 25 && inv[3] > 0) return 3;
        if (rem >= 10 && inv[2] > 0) return 2;
        if (rem >= 5  && inv[1] > 0) return 1;
        return 0;
    endfunction

    function automatic int value(input int c);
        return (c == 3) ? 25 : (c == 2) ? 10 : 5;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 4; i++) inv[i] = 0;
        e_rem = 0; e_coin = 0; e_vld = 0; e_busy = 0; e_done = 0; e_err = 0;
        m_live = 1'b1;
    endtask

    task automatic m_tick(output bit r);
        @(posedge clk);
        r = !hrst_n;
        e_done = 1'b0;
        if (r) m_reset();
    endtask

    task automatic m_payout();
        bit r;
        int c;
        int waited;
        forever begin
            m_tick(r);
            if (r) return;
            if (e_rem == 0) begin
                e_done = 1'b1; e_busy = 1'b0;
                m_tick(r);
                return;
            end
            c = pick(e_rem);
            if (c == 0) begin
                e_err = 1'b1; e_busy = 1'b0;
                m_tick(r);
                return;
            end
            e_vld = 1'b1; e_coin = c; waited = 0;
            forever begin
                m_tick(r);
                if (r) return;
                if (dsp_if.eject_ready) begin
                    e_rem = e_rem - value(c);
                    inv[c] = inv[c] - 1;
                    e_vld = 1'b0;
                    break;
                end
                waited++;
                if (waited == TIMEOUT) begin
                    e_vld = 1'b0; e_err = 1'b1; e_busy = 1'b0;
                    m_tick(r);
                    return;
                end
            end
        end
    endtask

    initial begin : model
        bit r;
        int c;
        forever begin
            m_tick(r);
            if (!r && m_live) begin
                if (dsp_if.refill && dsp_if.refill_coin != 2'b00) begin
                    c = int'(dsp_if.refill_coin);
                    inv[c] = inv[c] + int'(dsp_if.refill_qty);
                    if (inv[c] > MAX_COINS) inv[c] = MAX_COINS;
                end
                if (dsp_if.start) begin
                    e_rem = int'(dsp_if.amount); e_err = 1'b0; e_busy = 1'b1;
                    m_payout();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("coin_valid", int'(dsp_if.coin_valid), int'(e_vld));
            if (e_vld) chk("coin_out", int'(dsp_if.coin_out), e_coin);
            chk("busy", int'(dsp_if.busy), int'(e_busy));
            chk("done", int'(dsp_if.done), int'(e_done));
            chk("error", int'(dsp_if.error), int'(e_err));
            chk("remaining", int'(dsp_if.remaining), e_rem);
            chk("q_count", int'(dsp_if.q_count), inv[3]);
            chk("d_count", int'(dsp_if.d_count), inv[2]);
            chk("n_count", int'(dsp_if.n_count), inv[1]);
        end
    end

    int coin_log[$];
    int n_done = 0;
    int n_vld  = 0;

    always @(posedge clk)
        if (hrst_n && dsp_if.coin_valid && dsp_if.eject_ready) coin_log.push_back(int'(dsp_if.coin_out));

    always @(negedge clk) begin
        if (dsp_if.done) n_done++;
        if (dsp_if.coin_valid) n_vld++;
    end

    task automatic do_refill(input logic [1:0] c, input logic [3:0] q);
        dsp_if.refill = 1'b1; dsp_if.refill_coin = c; dsp_if.refill_qty = q;
        @(negedge clk);
        dsp_if.refill = 1'b0; dsp_if.refill_coin = 2'b00; dsp_if.refill_qty = 4'd0;
    endtask

    task automatic do_start(input logic [15:0] a);
        dsp_if.start = 1'b1; dsp_if.amount = a;
        @(negedge clk);
        dsp_if.start = 1'b0;
    endtask

    task automatic wait_payout(input string name, input int budget);
        int n;
        n = 0;
        while (dsp_if.busy === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(dsp_if.busy), 0);
        @(negedge clk);
    endtask

    task automatic chk_counts(input string name, input int q, input int d, input int n);
        chk({name, "_q"}, int'(dsp_if.q_count), q);
        chk({name, "_d"}, int'(dsp_if.d_count), d);
        chk({name, "_n"}, int'(dsp_if.n_count), n);
    endtask

    int t1_exp[4] = '{3, 3, 2, 1};
    int done_base;
    int vld_base;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        hrst_n = 1'b0;
        dsp_if.start = 1'b0; dsp_if.amount = 16'd0; dsp_if.eject_ready = 1'b0;
        dsp_if.refill = 1'b0; dsp_if.refill_coin = 2'b00; dsp_if.refill_qty = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(dsp_if.busy), 0);
        chk("rst_coin_valid", int'(dsp_if.coin_valid), 0);
        chk("rst_remaining", int'(dsp_if.remaining), 0);
        chk_counts("rst", 0, 0, 0);
        hrst_n = 1'b1;
        @(negedge clk);

        // 65c with full tubes: Q Q D N.
        do_refill(2'b11, 4'd4); do_refill(2'b10, 4'd4); do_refill(2'b01, 4'd4);
        dsp_if.eject_ready = 1'b1;
        coin_log.delete(); done_base = n_done;
        do_start(16'd65);
        wait_payout("t1_finish", 50);
        chk("t1_ncoins", coin_log.size(), 4);
        if (coin_log.size() == 4)
            for (int i = 0; i < 4; i++) chk("t1_coin_seq", coin_log[i], t1_exp[i]);
        chk("t1_done_pulses", n_done - done_base, 1);
        chk("t1_remaining", int'(dsp_if.remaining), 0);
        chk("t1_error", int'(dsp_if.error), 0);
        chk_counts("t1", 2, 3, 3);

        // Drain quarters, then 30c falls back to dimes.
        do_start(16'd50);
        wait_payout("t2_drain", 50);
        do_refill(2'b10, 4'd7);
        coin_log.delete();
        do_start(16'd30);
        wait_payout("t2_finish", 50);
        chk("t2_ncoins", coin_log.size(), 3);
        foreach (coin_log[i]) chk("t2_coin_dime", coin_log[i], 2);
        chk_counts("t2", 0, 7, 3);

        // Zero amount: done right after edge k+1, no coins.
        done_base = n_done; vld_base = n_vld;
        do_start(16'd0);
        chk("t3_busy_k", int'(dsp_if.busy), 1);
        @(negedge clk);
        chk("t3_done_k1", int'(dsp_if.done), 1);
        @(negedge clk);
        chk("t3_done_pulses", n_done - done_base, 1);
        chk("t3_no_valid", n_vld - vld_base, 0);
        chk_counts("t3", 0, 7, 3);

        // 7c: one nickel, then residue 2 is an error.
        do_refill(2'b01, 4'd2);
        coin_log.delete(); done_base = n_done;
        do_start(16'd7);
        wait_payout("t4_finish", 50);
        chk("t4_ncoins", coin_log.size(), 1);
        if (coin_log.size() > 0) chk("t4_coin_nickel", coin_log[0], 1);
        chk("t4_error", int'(dsp_if.error), 1);
        chk("t4_remaining", int'(dsp_if.remaining), 2);
        chk("t4_n_count", int'(dsp_if.n_count), 4);
        chk("t4_no_done", n_done - done_base, 0);
        do_start(16'd0);
        chk("t4_err_cleared", int'(dsp_if.error), 0);
        wait_payout("t4_clear_finish", 10);

        // Ejector never ready: quarter held, then timeout abort.
        do_refill(2'b11, 4'd5);
        dsp_if.eject_ready = 1'b0;
        coin_log.delete();
        do_start(16'd25);
        @(negedge clk);
        chk("t5_first_valid", int'(dsp_if.coin_valid), 1);
        chk("t5_first_coin", int'(dsp_if.coin_out), 3);
        wait_payout("t5_timeout", TIMEOUT + 20);
        chk("t5_error", int'(dsp_if.error), 1);
        chk("t5_remaining", int'(dsp_if.remaining), 25);
        chk("t5_q_count", int'(dsp_if.q_count), 5);
        chk("t5_ncoins", coin_log.size(), 0);

        // Reset mid-payout.
        do_start(16'd25);
        repeat (3) @(negedge clk);
        hrst_n = 1'b0;
        @(negedge clk);
        chk("t5r_coin_valid", int'(dsp_if.coin_valid), 0);
        chk("t5r_coin_out", int'(dsp_if.coin_out), 0);
        chk("t5r_busy", int'(dsp_if.busy), 0);
        chk("t5r_error", int'(dsp_if.error), 0);
        chk("t5r_remaining", int'(dsp_if.remaining), 0);
        chk_counts("t5r", 0, 0, 0);
        hrst_n = 1'b1;
        @(negedge clk);

        // Refill saturation, then start/refill ignored while busy.
        for (int i = 0; i < 13; i++) do_refill(2'b01, 4'd15);
        chk("t6_n_195", int'(dsp_if.n_count), 195);
        do_refill(2'b01, 4'd15);
        chk("t6_n_sat", int'(dsp_if.n_count), 200);
        do_refill(2'b10, 4'd4);
        done_base = n_done;
        do_start(16'd5);
        dsp_if.start = 1'b1; dsp_if.amount = 16'd100;
        dsp_if.refill = 1'b1; dsp_if.refill_coin = 2'b10; dsp_if.refill_qty = 4'd15;
        repeat (3) @(negedge clk);
        dsp_if.start = 1'b0; dsp_if.refill = 1'b0; dsp_if.refill_coin = 2'b00; dsp_if.refill_qty = 4'd0;
        chk("t6_rem_kept", int'(dsp_if.remaining), 5);
        chk("t6_d_kept", int'(dsp_if.d_count), 4);
        dsp_if.eject_ready = 1'b1;
        wait_payout("t6_finish", 20);
        chk("t6_done_pulses", n_done - done_base, 1);
        chk("t6_remaining", int'(dsp_if.remaining), 0);
        chk("t6_error", int'(dsp_if.error), 0);
        chk_counts("t6", 0, 4, 199);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
